// File: rtl/arm_shift_pkg.sv
// -----------------------------------------------------------------------------
// arm_shift_pkg
// Shared definitions for the ARM operand-2 shifter and the rotate-immediate
// encoder.
//   - enc_state_e : state encoding of the immediate-encoder FSM
//   - IMM_W/ROT_W : field widths of the data-processing immediate
//   - ROT_MAX     : largest rotate_imm field value
//   - shift_type_e: shift-type field encodings used by shifter_32
//   - imm_fits()  : helper, true when a 32-bit word fits in the low 8 bits
// -----------------------------------------------------------------------------
package arm_shift_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IMM_W  = 8;
    localparam int unsigned ROT_W  = 4;

    localparam logic [ROT_W-1:0] ROT_MAX  = 4'd15;
    localparam logic [ROT_W-1:0] ROT_ZERO = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_DONE   = 2'b10
    } enc_state_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // A rotated candidate is a valid immediate when nothing above bit 7 is set.
    function automatic logic imm_fits(input logic [DATA_W-1:0] cand);
        return (cand[DATA_W-1:IMM_W] == 24'd0);
    endfunction

endpackage

// File: rtl/rot_imm_rol.sv
// -----------------------------------------------------------------------------
// rot_imm_rol
// Combinational 32-bit rotate-left by an even amount {rot,1'b0} (0..30).
// Undoes the ROR(2*rot) applied when decoding an operand-2 immediate, so the
// same block serves both the encoder search and a decode-side checker.
// Ports:
//   data   : input  [31:0] word to rotate
//   rot    : input  [3:0]  rotate field; rotation amount is 2*rot
//   result : output [31:0] data ROL (2*rot)
// -----------------------------------------------------------------------------
module rot_imm_rol
    import arm_shift_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [ROT_W-1:0]  rot,
    output logic [DATA_W-1:0] result
);

    logic [4:0]          amt_s;
    logic [2*DATA_W-1:0] dbl_s;

    // Shifting the doubled word left leaves the wrapped bits in the upper half.
    always_comb begin
        amt_s  = {rot, 1'b0};
        dbl_s  = {data, data} << amt_s;
        result = dbl_s[2*DATA_W-1:DATA_W];
    end

endmodule

// File: rtl/rot_imm_encoder.sv
// -----------------------------------------------------------------------------
// rot_imm_encoder
// Multi-cycle search for the ARM data-processing immediate of a 32-bit
// constant: finds the smallest rotate_imm such that
// value == imm8 ROR (2*rotate_imm), trying one rotation per clock.
// Also reports the shifter carry-out the encoded operand would produce.
// Ports:
//   clk        : input        rising-edge clock
//   reset      : input        asynchronous active-high reset
//   start      : input        request pulse, accepted in IDLE or DONE
//   value      : input  [31:0] constant to encode, sampled on accept
//   carryFlag  : input        current C flag, sampled on accept
//   busy       : output       search in progress
//   done       : output       one-cycle result-valid pulse
//   found      : output       value is encodable (held)
//   imm8       : output [7:0] encoded immediate (held)
//   rotate_imm : output [3:0] encoded rotate field (held)
//   carryOut   : output       carry-out of the encoded operand (held)
// Result outputs only change when a search completes or on reset.
// -----------------------------------------------------------------------------
module rot_imm_encoder
    import arm_shift_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    input  logic              carryFlag,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [IMM_W-1:0]  imm8,
    output logic [ROT_W-1:0]  rotate_imm,
    output logic              carryOut
);

    enc_state_e        state_r, state_s;
    logic [DATA_W-1:0] v_r, v_s;
    logic              c_r, c_s;
    logic [ROT_W-1:0]  rot_r, rot_s;
    logic              found_r, found_s;
    logic [IMM_W-1:0]  imm8_r, imm8_s;
    logic [ROT_W-1:0]  rot_imm_r, rot_imm_s;
    logic              carry_r, carry_s;

    logic [DATA_W-1:0] cand_s;
    logic              hit_s;

    rot_imm_rol u_rol (
        .data   (v_r),
        .rot    (rot_r),
        .result (cand_s)
    );

    // Candidate test for the rotation currently being tried.
    always_comb begin
        hit_s = imm_fits(cand_s);
    end

    // Next-state and next-result logic; everything holds unless stated.
    always_comb begin
        state_s   = state_r;
        v_s       = v_r;
        c_s       = c_r;
        rot_s     = rot_r;
        found_s   = found_r;
        imm8_s    = imm8_r;
        rot_imm_s = rot_imm_r;
        carry_s   = carry_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    v_s     = value;
                    c_s     = carryFlag;
                    rot_s   = ROT_ZERO;
                    state_s = ST_SEARCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (hit_s) begin
                    found_s   = 1'b1;
                    imm8_s    = cand_s[IMM_W-1:0];
                    rot_imm_s = rot_r;
                    // With no rotation the shifter passes C through untouched;
                    // otherwise carry-out is the MSB of the rotated result,
                    // which is the original value's bit 31.
                    if (rot_r == ROT_ZERO) begin
                        carry_s = c_r;
                    end else begin
                        carry_s = v_r[DATA_W-1];
                    end
                    state_s = ST_DONE;
                end else if (rot_r == ROT_MAX) begin
                    found_s   = 1'b0;
                    imm8_s    = 8'd0;
                    rot_imm_s = ROT_ZERO;
                    carry_s   = 1'b0;
                    state_s   = ST_DONE;
                end else begin
                    rot_s   = rot_r + 4'd1;
                    state_s = ST_SEARCH;
                end
            end
            ST_DONE: begin
                // A new request may chain straight out of DONE.
                if (start) begin
                    v_s     = value;
                    c_s     = carryFlag;
                    rot_s   = ROT_ZERO;
                    state_s = ST_SEARCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, search operands and held results; reset clears all immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            v_r       <= 32'd0;
            c_r       <= 1'b0;
            rot_r     <= 4'd0;
            found_r   <= 1'b0;
            imm8_r    <= 8'd0;
            rot_imm_r <= 4'd0;
            carry_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            v_r       <= v_s;
            c_r       <= c_s;
            rot_r     <= rot_s;
            found_r   <= found_s;
            imm8_r    <= imm8_s;
            rot_imm_r <= rot_imm_s;
            carry_r   <= carry_s;
        end
    end

    // Status decodes straight from the state register; results from holds.
    always_comb begin
        busy       = (state_r == ST_SEARCH);
        done       = (state_r == ST_DONE);
        found      = found_r;
        imm8       = imm8_r;
        rotate_imm = rot_imm_r;
        carryOut   = carry_r;
    end

endmodule

// File: tb/tb_rot_imm_encoder.sv
module tb_rot_imm_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        carryFlag;
    logic        busy;
    logic        done;
    logic        found;
    logic [7:0]  imm8;
    logic [3:0]  rotate_imm;
    logic        carryOut;

    int checks;
    int errors;

    rot_imm_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .value      (value),
        .carryFlag  (carryFlag),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .imm8       (imm8),
        .rotate_imm (rotate_imm),
        .carryOut   (carryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start for one edge (E0); returns 1 time unit after E0.
    task automatic launch(input logic [31:0] v, input logic cf);
        start     = 1'b1;
        value     = v;
        carryFlag = cf;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen; -1 if the bound expires.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) n = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; value = 32'd0; carryFlag = 1'b0;
        #12;
        checks++;
        if ({busy, done, found, imm8, rotate_imm, carryOut} !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0000", {busy, done, found, imm8, rotate_imm, carryOut});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rot0;
        int n;
        launch(32'h0000_00FF, 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rot0_busy got %b want 1", busy); end
        wait_done(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL rot0_latency got %0d want 1", n); end
        checks++;
        if ({found, imm8, rotate_imm, carryOut} !== {1'b1, 8'hFF, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL rot0_result got %b/%h/%0d/%b want 1/ff/0/1", found, imm8, rotate_imm, carryOut);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rot0_busy_done got %b want 0", busy); end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rot0_done_pulse got %b want 0", done); end
        checks++;
        if (imm8 !== 8'hFF || found !== 1'b1) begin
            errors++; $display("FAIL rot0_hold got %b/%h want 1/ff", found, imm8);
        end
    endtask

    task automatic test_rot4;
        int n;
        launch(32'hFF00_0000, 1'b0);
        wait_done(n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL rot4_latency got %0d want 5", n); end
        checks++;
        if ({found, imm8, rotate_imm, carryOut} !== {1'b1, 8'hFF, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL rot4_result got %b/%h/%0d/%b want 1/ff/4/1", found, imm8, rotate_imm, carryOut);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rot2;
        int n;
        launch(32'hF000_000F, 1'b0);
        wait_done(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL rot2_latency got %0d want 3", n); end
        checks++;
        if ({found, imm8, rotate_imm, carryOut} !== {1'b1, 8'hFF, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL rot2_result got %b/%h/%0d/%b want 1/ff/2/1", found, imm8, rotate_imm, carryOut);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_not_found;
        int n;
        launch(32'h0000_0102, 1'b1);
        checks++;
        if (imm8 !== 8'hFF || rotate_imm !== 4'd2 || found !== 1'b1) begin
            errors++; $display("FAIL nf_hold_during_search got %b/%h/%0d want 1/ff/2", found, imm8, rotate_imm);
        end
        wait_done(n);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL nf_latency got %0d want 16", n); end
        checks++;
        if ({found, imm8, rotate_imm, carryOut} !== 14'd0) begin
            errors++;
            $display("FAIL nf_result got %b/%h/%0d/%b want 0/00/0/0", found, imm8, rotate_imm, carryOut);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignore;
        int n;
        launch(32'h0000_0102, 1'b1);    // E0
        @(posedge clk); #1;             // E1
        @(posedge clk); #1;             // E2
        value = 32'h0000_00FF; carryFlag = 1'b0; start = 1'b1;
        @(posedge clk); #1;             // E3, start ignored
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", busy); end
        wait_done(n);
        checks++;
        if (n !== 13) begin errors++; $display("FAIL ignore_latency got %0d want 13", n); end
        checks++;
        if (found !== 1'b0 || imm8 !== 8'h00) begin
            errors++; $display("FAIL ignore_result got %b/%h want 0/00", found, imm8);
        end
        @(posedge clk);
        #1;
        launch(32'h0000_0000, 1'b0);
        wait_done(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", n); end
        checks++;
        if ({found, imm8, rotate_imm, carryOut} !== {1'b1, 8'h00, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL zero_result got %b/%h/%0d/%b want 1/00/0/0", found, imm8, rotate_imm, carryOut);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int n;
        launch(32'h0000_00FF, 1'b0);
        wait_done(n);
        checks++;
        if (n !== 1 || carryOut !== 1'b0) begin
            errors++; $display("FAIL b2b_first got %0d/%b want 1/0", n, carryOut);
        end
        launch(32'hFF00_0000, 1'b0);    // accepted while in DONE
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept got done=%b busy=%b want 0/1", done, busy);
        end
        wait_done(n);
        checks++;
        if (n !== 5 || rotate_imm !== 4'd4 || imm8 !== 8'hFF) begin
            errors++; $display("FAIL b2b_second got %0d/%0d/%h want 5/4/ff", n, rotate_imm, imm8);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int n;
        int seen;
        launch(32'h0000_00FF, 1'b1);
        wait_done(n);
        @(posedge clk); #1;
        launch(32'h0000_0102, 1'b0);    // E0
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, found, imm8, rotate_imm, carryOut} !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0000", {busy, done, found, imm8, rotate_imm, carryOut});
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", seen); end
        launch(32'hFF00_0000, 1'b0);
        wait_done(n);
        checks++;
        if (n !== 5 || {found, imm8, rotate_imm, carryOut} !== {1'b1, 8'hFF, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL midreset_restart got %0d %b/%h/%0d/%b want 5 1/ff/4/1", n, found, imm8, rotate_imm, carryOut);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rot0();
        test_rot4();
        test_rot2();
        test_not_found();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rot_imm_encoder.md
Name: rot_imm_encoder

Overview:
Multi-cycle encoder that produces the ARM data-processing immediate for a 32-bit constant. It searches for an 8-bit immediate and 4-bit rotate field such that `value == imm8 ROR (2*rotate_imm)`. It is the inverse of the rotate-immediate decode that shifter_32 performs on operand 2. It sits beside the instruction-assembly/decode path and also reports the shifter carry-out the encoded operand would produce.

Parameters:
None. Data width is fixed at 32, imm8 at 8 bits and rotate_imm at 4 bits, all set by the ARM encoding.

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; accepted only when busy=0
value  input  32  constant to encode; sampled on the accepting edge
carryFlag  input  1  current C flag; sampled with value
busy  output  1  high while a search is in progress
done  output  1  one-cycle pulse when a result is valid
found  output  1  1 = value is encodable; held until the next accepted start
imm8  output  8  encoded immediate; held
rotate_imm  output  4  encoded rotate field; held
carryOut  output  1  shifter carry-out of the encoded operand; held

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - busy, done, found, imm8, rotate_imm and carryOut all go to 0 immediately.
  - Reset mid-search abandons the search with no done pulse.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - When start=1, latch value into v_q and carryFlag into c_q, set rot=0, go to SEARCH, busy=1.
- SEARCH (one candidate per cycle):
  - Candidate: cand = v_q ROL (2*rot), a 32-bit rotate with wrap-around; 2*rot is a 5-bit amount, 0..30.
  - Hit when cand[31:8]==0. On a hit: found=1, imm8=cand[7:0], rotate_imm=rot, carryOut = (rot==0) ? c_q : v_q[31]; go to DONE.
  - No hit and rot==15: found=0, imm8=0, rotate_imm=0, carryOut=0; go to DONE.
  - Otherwise rot=rot+1.
  - The smallest rotate that works always wins. value=0 hits at rot=0 with imm8=0.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start is also accepted in DONE: go straight to SEARCH, and done still deasserts.
- Latency, counting edge E0 as the edge that accepts start:
  - Hit at rotation k: done is high after edge E(k+1), i.e. 1..16 cycles.
  - Not found: done is high after E16.
- Output holding: result outputs change only on a SEARCH→DONE transition or on reset. They hold their value across IDLE and across a new search until that search completes.
- Simultaneous events:
  - start while busy=1 is ignored; value and carryFlag changes during SEARCH have no effect.
  - reset wins over everything.
- busy is combinationally `state==SEARCH`. done is `state==DONE`.

Decomposition:
- Shared package arm_shift_pkg: state encoding (IDLE/SEARCH/DONE), IMM_W=8, ROT_W=4, ROT_MAX=15, and the shift-type encodings already used by shifter_32 (LSL=00, LSR=01, ASR=10, ROR=11).
- One natural sub-module, rot_imm_rol: combinational 32-bit rotate-left by {rot,1'b0}. It is reusable by the decode-side checker.

Test Plan:
- value=0x000000FF, carryFlag=1: done after E1; found=1, imm8=0xFF, rotate_imm=0, carryOut=1 (C passes through when rot=0).
- value=0xFF000000, carryFlag=0: done after E5; found=1, imm8=0xFF, rotate_imm=4, carryOut=1 (value[31]).
- value=0xF000000F: done after E3; found=1, imm8=0xFF, rotate_imm=2, carryOut=1.
- value=0x00000102 (not encodable): done after E16; found=0, imm8=0, rotate_imm=0, carryOut=0.
- value=0x00000102, second start with value=0xFF at E3: second start ignored; after E16 found=0. Then start 0x00000000 with carryFlag=0: done after E1, found=1, imm8=0, rotate_imm=0, carryOut=0.
- Reset pulse after E5 of a 0x00000102 search: busy, done, found, imm8, rotate_imm and carryOut are 0 immediately; no done pulse follows. A new start of 0xFF000000 then completes normally after E5.
